// File: rtl/dff_dual_deque.sv
// dff_dual_deque: two independent double-ended queues held in flip-flops and
// driven from one shared command port. Each channel keeps a circular buffer
// with a head pointer and an occupancy count. One command is accepted per
// cycle, and its response is registered and appears on the following cycle.
module dff_dual_deque #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_ch,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       empty,
    output logic [1:0]       full,
    output logic [CW-1:0]    count0,
    output logic [CW-1:0]    count1
);

    localparam logic [2:0] OP_PUSH_FRONT = 3'd0;
    localparam logic [2:0] OP_PUSH_BACK  = 3'd1;
    localparam logic [2:0] OP_POP_FRONT  = 3'd2;
    localparam logic [2:0] OP_POP_BACK   = 3'd3;
    localparam logic [2:0] OP_PEEK_FRONT = 3'd4;
    localparam logic [2:0] OP_PEEK_BACK  = 3'd5;
    localparam logic [2:0] OP_CLEAR      = 3'd6;

    localparam logic [PW-1:0] ONE_PW = PW'(1);
    localparam logic [CW-1:0] ONE_CW = CW'(1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q   [2][DEPTH];
    logic [PW-1:0]    head_q  [2];
    logic [CW-1:0]    count_q [2];

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;

    logic [PW-1:0]    head_d;
    logic [CW-1:0]    count_d;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    logic [PW-1:0]    sel_head;
    logic [CW-1:0]    sel_count;
    logic             sel_full;
    logic             sel_empty;
    logic [PW-1:0]    idx_back;
    logic [PW-1:0]    idx_tail;
    logic [PW-1:0]    idx_pre;

    // Selected channel's state and its derived circular-buffer indices.
    // The indices are PW bits wide, so they wrap modulo DEPTH on their own.
    assign sel_head  = head_q[cmd_ch];
    assign sel_count = count_q[cmd_ch];
    assign sel_full  = (sel_count == FULL_C);
    assign sel_empty = (sel_count == '0);
    assign idx_tail  = sel_head + sel_count[PW-1:0];
    assign idx_back  = idx_tail - ONE_PW;
    assign idx_pre   = sel_head - ONE_PW;

    // Decode the command into the selected channel's next state, a
    // single-entry storage write, and the registered response.
    always_comb begin
        head_d      = sel_head;
        count_d     = sel_count;
        wr_en       = 1'b0;
        wr_idx      = idx_tail;
        rsp_valid_d = cmd_valid;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        if (cmd_valid) begin
            case (cmd_op)
                OP_PUSH_FRONT: begin
                    if (sel_full) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        head_d  = idx_pre;
                        wr_en   = 1'b1;
                        wr_idx  = idx_pre;
                        count_d = sel_count + ONE_CW;
                    end
                end
                OP_PUSH_BACK: begin
                    if (sel_full) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = idx_tail;
                        count_d = sel_count + ONE_CW;
                    end
                end
                OP_POP_FRONT: begin
                    if (sel_empty) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_data_d = mem_q[cmd_ch][sel_head];
                        head_d     = sel_head + ONE_PW;
                        count_d    = sel_count - ONE_CW;
                    end
                end
                OP_POP_BACK: begin
                    if (sel_empty) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_data_d = mem_q[cmd_ch][idx_back];
                        count_d    = sel_count - ONE_CW;
                    end
                end
                OP_PEEK_FRONT: begin
                    if (sel_empty) rsp_err_d = 1'b1;
                    else           rsp_data_d = mem_q[cmd_ch][sel_head];
                end
                OP_PEEK_BACK: begin
                    if (sel_empty) rsp_err_d = 1'b1;
                    else           rsp_data_d = mem_q[cmd_ch][idx_back];
                end
                OP_CLEAR: begin
                    head_d  = '0;
                    count_d = '0;
                end
                default: rsp_err_d = 1'b1;
            endcase
        end
    end

    // State and response registers. Reset takes priority over any command
    // presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            head_q      <= '{default: '0};
            count_q     <= '{default: '0};
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[cmd_ch][wr_idx] <= cmd_data;
            end
            if (cmd_valid) begin
                head_q[cmd_ch]  <= head_d;
                count_q[cmd_ch] <= count_d;
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign count0    = count_q[0];
    assign count1    = count_q[1];
    assign empty     = {count_q[1] == '0, count_q[0] == '0};
    assign full      = {count_q[1] == FULL_C, count_q[0] == FULL_C};

endmodule

// File: tb/tb_dff_dual_deque.sv
// Testbench for dff_dual_deque. A queue-based reference model predicts each
// cycle's response and status, and a scoreboard entry is pushed whenever
// stimulus is driven. A monitor pops and compares that entry one clock edge
// later. The scenario tasks also compare directly against known literal
// values.
module tb_dff_dual_deque;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ch;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic          rsp_valid;
    logic          rsp_err;
    logic [W-1:0]  rsp_data;
    logic [1:0]    empty;
    logic [1:0]    full;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    dff_dual_deque #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ch    (cmd_ch),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .empty     (empty),
        .full      (full),
        .count0    (count0),
        .count1    (count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic          v;
        logic          e;
        logic [W-1:0]  d;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
    } exp_t;

    exp_t         sb[$];
    exp_t         mx;
    logic [W-1:0] mq0[$];
    logic [W-1:0] mq1[$];
    int           checks   = 0;
    int           failures = 0;

    // Reference deque behaviour, one command at a time.
    task automatic model(input logic ch, input logic [2:0] op, input logic [W-1:0] data,
                         output logic e, output logic [W-1:0] d);
        logic [W-1:0] q[$];
        q = ch ? mq1 : mq0;
        e = 1'b0;
        d = '0;
        case (op)
            3'd0: if (q.size() == D) e = 1'b1; else q.push_front(data);
            3'd1: if (q.size() == D) e = 1'b1; else q.push_back(data);
            3'd2: if (q.size() == 0) e = 1'b1; else d = q.pop_front();
            3'd3: if (q.size() == 0) e = 1'b1; else d = q.pop_back();
            3'd4: if (q.size() == 0) e = 1'b1; else d = q[0];
            3'd5: if (q.size() == 0) e = 1'b1; else d = q[q.size()-1];
            3'd6: q.delete();
            default: e = 1'b1;
        endcase
        if (ch) mq1 = q;
        else    mq0 = q;
    endtask

    // Drive one cycle of stimulus on the falling edge and queue its expectation.
    task automatic cyc(input logic rst, input logic v, input logic ch,
                       input logic [2:0] op, input logic [W-1:0] data);
        exp_t x;
        @(negedge clk);
        rst_n     = ~rst;
        cmd_valid = v;
        cmd_ch    = ch;
        cmd_op    = op;
        cmd_data  = data;
        x = '0;
        if (rst) begin
            mq0.delete();
            mq1.delete();
        end else if (v) begin
            x.v = 1'b1;
            model(ch, op, data, x.e, x.d);
        end
        x.c0 = CW'(mq0.size());
        x.c1 = CW'(mq1.size());
        sb.push_back(x);
    endtask

    // Scoreboard monitor: checks each response and status just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mx = sb.pop_front();
            checks++;
            if ({rsp_valid, rsp_err, rsp_data} !== {mx.v, mx.e, mx.d}) begin
                failures++;
                $display("FAIL rsp t=%0t got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                         $time, rsp_valid, rsp_err, rsp_data, mx.v, mx.e, mx.d);
            end
            checks++;
            if (count0 !== mx.c0 || count1 !== mx.c1 ||
                empty !== {mx.c1 == 0, mx.c0 == 0} ||
                full !== {mx.c1 == CW'(D), mx.c0 == CW'(D)}) begin
                failures++;
                $display("FAIL status t=%0t got c0=%0d c1=%0d e=%b f=%b exp c0=%0d c1=%0d",
                         $time, count0, count1, empty, full, mx.c0, mx.c1);
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 1, 8'h55);
        settle();
        checks++;
        if (empty !== 2'b11 || full !== 2'b00 || count0 !== 0 || count1 !== 0 ||
            rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL reset got e=%b f=%b c0=%0d c1=%0d v=%b exp e=11 f=00 c0=0 c1=0 v=0",
                     empty, full, count0, count1, rsp_valid);
        end
    endtask

    task automatic test_fifo_order();
        logic [W-1:0] vals [3];
        vals = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'd1, vals[i]);
        settle();
        checks++;
        if (count0 !== 5'd3) begin
            failures++;
            $display("FAIL fifo_count got %0d exp 3", count0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 3'd2, 8'h00);
            settle();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== vals[i]) begin
                failures++;
                $display("FAIL fifo_pop%0d got v=%b e=%b d=%h exp v=1 e=0 d=%h",
                         i, rsp_valid, rsp_err, rsp_data, vals[i]);
            end
        end
        checks++;
        if (count0 !== 5'd0 || empty[0] !== 1'b1) begin
            failures++;
            $display("FAIL fifo_empty got c0=%0d e0=%b exp c0=0 e0=1", count0, empty[0]);
        end
    endtask

    task automatic test_push_front();
        cyc(0, 1, 1, 3'd0, 8'hA1);
        cyc(0, 1, 1, 3'd0, 8'hA2);
        cyc(0, 1, 1, 3'd2, 8'h00);
        settle();
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== 8'hA2) begin
            failures++;
            $display("FAIL pf_pop_front got e=%b d=%h exp e=0 d=a2", rsp_err, rsp_data);
        end
        cyc(0, 1, 1, 3'd3, 8'h00);
        settle();
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== 8'hA1) begin
            failures++;
            $display("FAIL pf_pop_back got e=%b d=%h exp e=0 d=a1", rsp_err, rsp_data);
        end
        cyc(0, 1, 1, 3'd2, 8'h00);
        settle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL pf_underflow got v=%b e=%b d=%h exp v=1 e=1 d=00",
                     rsp_valid, rsp_err, rsp_data);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < D; i++) cyc(0, 1, 0, 3'd1, W'(i));
        settle();
        checks++;
        if (full[0] !== 1'b1 || count0 !== 5'd16) begin
            failures++;
            $display("FAIL full_set got f0=%b c0=%0d exp f0=1 c0=16", full[0], count0);
        end
        cyc(0, 1, 0, 3'd1, 8'hEE);
        settle();
        checks++;
        if (rsp_err !== 1'b1 || count0 !== 5'd16) begin
            failures++;
            $display("FAIL overflow got e=%b c0=%0d exp e=1 c0=16", rsp_err, count0);
        end
        cyc(0, 1, 0, 3'd3, 8'h00);
        settle();
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== 8'h0F || empty[1] !== 1'b1) begin
            failures++;
            $display("FAIL full_pop_back got e=%b d=%h e1=%b exp e=0 d=0f e1=1",
                     rsp_err, rsp_data, empty[1]);
        end
    endtask

    task automatic test_wrap();
        cyc(0, 1, 0, 3'd6, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 3'd1, W'(8'h80 + i));
            cyc(0, 1, 0, 3'd2, 8'h00);
        end
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 3'd0, W'(8'h40 + i));
        cyc(0, 1, 0, 3'd4, 8'h00);
        settle();
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== 8'h4B || count0 !== 5'd12) begin
            failures++;
            $display("FAIL wrap_peek_front got e=%b d=%h c0=%0d exp e=0 d=4b c0=12",
                     rsp_err, rsp_data, count0);
        end
        cyc(0, 1, 0, 3'd5, 8'h00);
        settle();
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== 8'h40 || count0 !== 5'd12) begin
            failures++;
            $display("FAIL wrap_peek_back got e=%b d=%h c0=%0d exp e=0 d=40 c0=12",
                     rsp_err, rsp_data, count0);
        end
    endtask

    task automatic test_clear_illegal();
        cyc(0, 1, 0, 3'd6, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 3'd1, W'(8'hC0 + i));
        settle();
        checks++;
        if (count0 !== 5'd5) begin
            failures++;
            $display("FAIL clr_pre got c0=%0d exp 5", count0);
        end
        cyc(0, 1, 0, 3'd6, 8'h00);
        settle();
        checks++;
        if (empty[0] !== 1'b1 || rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL clear got e0=%b v=%b err=%b exp e0=1 v=1 err=0",
                     empty[0], rsp_valid, rsp_err);
        end
        cyc(0, 1, 0, 3'd2, 8'h00);
        settle();
        checks++;
        if (rsp_err !== 1'b1) begin
            failures++;
            $display("FAIL clr_pop got err=%b exp 1", rsp_err);
        end
        cyc(0, 1, 1, 3'd1, 8'h77);
        cyc(0, 1, 1, 3'd7, 8'h99);
        settle();
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 8'h00 || count1 !== 5'd1 || count0 !== 5'd0) begin
            failures++;
            $display("FAIL illegal got e=%b d=%h c1=%0d c0=%0d exp e=1 d=00 c1=1 c0=0",
                     rsp_err, rsp_data, count1, count0);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 0, 3'd1, 8'h01);
        cyc(0, 1, 0, 3'd1, 8'h02);
        cyc(1, 1, 0, 3'd1, 8'h99);
        settle();
        checks++;
        if (count0 !== 5'd0 || count1 !== 5'd0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got c0=%0d c1=%0d v=%b exp c0=0 c1=0 v=0",
                     count0, count1, rsp_valid);
        end
        cyc(0, 1, 0, 3'd2, 8'h00);
        settle();
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_pop got e=%b d=%h exp e=1 d=00", rsp_err, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            cyc(0, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), W'($urandom_range(0, 255)));
        end
        cyc(0, 0, 0, 3'd0, 8'h00);
        settle();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        test_reset();
        test_fifo_order();
        test_push_front();
        test_full();
        test_wrap();
        test_clear_illegal();
        test_reset_mid();
        test_back_to_back();
        settle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
